// File: rtl/logic_unit_seq.sv
// Multi-cycle bitwise logic unit: NOT/AND/OR/XOR on WIDTH-bit operands, SLICE bits per cycle.
// Optional feature macro LU_INVB_EN adds an inv_b input that complements operand B (ANDN/ORN/XNOR).
module logic_unit_seq #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
`ifdef LU_INVB_EN
    input  logic             inv_b,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    generate
        if (WIDTH < 1 || SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_cfg
            $error("logic_unit_seq: WIDTH must be >=1 and a multiple of SLICE");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;

    logic [31:0]      w_shamt;
    logic [SLICE-1:0] w_a_sl;
    logic [SLICE-1:0] w_b_sl;
    logic [SLICE-1:0] w_res_sl;
    logic [WIDTH-1:0] w_next_result;
    logic             w_last;
    logic             w_accept;

    function automatic logic [SLICE-1:0] f_slice(input logic [1:0]       op_i,
                                                 input logic [SLICE-1:0] a_i,
                                                 input logic [SLICE-1:0] b_i);
        case (op_i)
            2'b00:   return ~a_i;
            2'b01:   return a_i & b_i;
            2'b10:   return a_i | b_i;
            default: return a_i ^ b_i;
        endcase
    endfunction

`ifdef LU_INVB_EN
    logic r_inv_b;
    assign w_b_sl = r_inv_b ? ~SLICE'(r_b >> w_shamt) : SLICE'(r_b >> w_shamt);
`else
    assign w_b_sl = SLICE'(r_b >> w_shamt);
`endif

    assign w_shamt  = 32'(r_cnt) * SLICE;
    assign w_a_sl   = SLICE'(r_a >> w_shamt);
    assign w_res_sl = f_slice(r_op, w_a_sl, w_b_sl);
    assign w_last   = (r_cnt == LAST);
    assign w_accept = (r_state == S_IDLE) && in_valid;
    // Result is cleared on accept, so OR-ing the shifted slice in leaves other bits untouched.
    assign w_next_result = r_result | (WIDTH'(w_res_sl) << w_shamt);

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        busy        = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = S_BUSY;
            end
            S_BUSY: begin
                busy = 1'b1;
                if (w_last) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
`ifdef LU_INVB_EN
            r_inv_b  <= 1'b0;
`endif
        end else if (w_accept) begin
            r_cnt    <= '0;
            r_a      <= data_a;
            r_b      <= data_b;
            r_op     <= op;
            r_result <= '0;
            r_zero   <= 1'b0;
`ifdef LU_INVB_EN
            r_inv_b  <= inv_b;
`endif
        end else if (r_state == S_BUSY) begin
            r_result <= w_next_result;
            if (w_last) r_zero <= (w_next_result == '0);
            else        r_cnt  <= r_cnt + 1'b1;
        end
    end

    assign result = r_result;
    assign zero   = r_zero;

endmodule

// File: tb/tb_logic_unit_seq.sv
// Directed self-checking bench for logic_unit_seq (WIDTH=32 with SLICE=8 and SLICE=32).
module tb_logic_unit_seq;

    logic        clock;
    logic        reset_n;
    logic        in_valid, in_ready, out_valid, out_ready, zero, busy;
    logic [1:0]  op;
    logic [31:0] data_a, data_b, result;
`ifdef LU_INVB_EN
    logic        inv_b;
    logic        w_inv_b1;
`endif

    logic        in_valid1, in_ready1, out_valid1, out_ready1, zero1, busy1;
    logic [1:0]  op1;
    logic [31:0] data_a1, data_b1, result1;

    int n_cmp = 0;
    int n_mis = 0;
    int lat;

    logic_unit_seq #(.WIDTH(32), .SLICE(8)) u_dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .data_a(data_a), .data_b(data_b),
`ifdef LU_INVB_EN
        .inv_b(inv_b),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .busy(busy)
    );

`ifdef LU_INVB_EN
    assign w_inv_b1 = 1'b0;
`endif

    logic_unit_seq #(.WIDTH(32), .SLICE(32)) u_dut1 (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid1), .in_ready(in_ready1), .op(op1),
        .data_a(data_a1), .data_b(data_b1),
`ifdef LU_INVB_EN
        .inv_b(w_inv_b1),
`endif
        .out_valid(out_valid1), .out_ready(out_ready1),
        .result(result1), .zero(zero1), .busy(busy1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Accept one request, scribble on the inputs while busy, wait for out_valid.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int l);
        in_valid = 1'b1;
        op       = o;
        data_a   = a;
        data_b   = b;
        tick();
        data_a = 32'hFFFF_FFFF;
        data_b = 32'hA5A5_A5A5;
        op     = 2'b11;
        l = 0;
        while (!out_valid && l < 20) begin
            tick();
            l++;
        end
        in_valid = 1'b0;
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_ovld_after"}, 64'(out_valid), 64'd0);
        chk({tag, "_irdy_after"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        reset_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; op = 2'b00; data_a = '0; data_b = '0;
        in_valid1 = 1'b0; out_ready1 = 1'b0; op1 = 2'b00; data_a1 = '0; data_b1 = '0;
`ifdef LU_INVB_EN
        inv_b = 1'b0;
`endif
        tick();
        tick();
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_zero", 64'(zero), 64'd0);
        reset_n = 1'b1;
        tick();

        issue(2'b00, 32'h0F0F_00FF, 32'h1234_5678, lat);
        chk("not_latency", 64'(lat), 64'd4);
        chk("not_result", 64'(result), 64'hF0F0_FF00);
        chk("not_zero", 64'(zero), 64'd0);
        chk("not_busy", 64'(busy), 64'd0);
        handshake("not");

        issue(2'b01, 32'hFFFF_0000, 32'h0000_FFFF, lat);
        chk("and_latency", 64'(lat), 64'd4);
        chk("and_result", 64'(result), 64'd0);
        chk("and_zero", 64'(zero), 64'd1);
        handshake("and");

        issue(2'b11, 32'h1234_5678, 32'h1234_5678, lat);
        chk("xor_latency", 64'(lat), 64'd4);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("xor_hold_valid", 64'(out_valid), 64'd1);
            chk("xor_hold_result", 64'(result), 64'd0);
            chk("xor_hold_zero", 64'(zero), 64'd1);
        end
        handshake("xor");

        issue(2'b10, 32'h0F00_F00F, 32'hF000_0F00, lat);
        chk("or_result", 64'(result), 64'hFF00_FF0F);
        chk("or_zero", 64'(zero), 64'd0);
        handshake("or");

        // Abort an OR during its second busy cycle; only slice 0 has been written at that point.
        in_valid = 1'b1; op = 2'b10; data_a = 32'h00FF_0000; data_b = 32'h0000_00F0;
        tick();
        in_valid = 1'b0;
        chk("abort_busy", 64'(busy), 64'd1);
        chk("abort_irdy_busy", 64'(in_ready), 64'd0);
        tick();
        chk("abort_partial", 64'(result), 64'h0000_00F0);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_result", 64'(result), 64'd0);
        chk("abort_busy_low", 64'(busy), 64'd0);
        lat = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid) lat++;
        end
        chk("abort_no_valid", 64'(lat), 64'd0);

`ifdef LU_INVB_EN
        inv_b = 1'b1;
        issue(2'b01, 32'hFFFF_FFFF, 32'h0000_00FF, lat);
        inv_b = 1'b0;
        chk("andn_result", 64'(result), 64'hFFFF_FF00);
        handshake("andn");
        inv_b = 1'b1;
        issue(2'b00, 32'h0000_FFFF, 32'h1111_1111, lat);
        inv_b = 1'b0;
        chk("not_invb_result", 64'(result), 64'hFFFF_0000);
        handshake("not_invb");
`endif

        // Full-width slice: a single busy cycle.
        in_valid1 = 1'b1; op1 = 2'b11; data_a1 = 32'hFFFF_0000; data_b1 = 32'h0F0F_0F0F;
        tick();
        in_valid1 = 1'b0;
        chk("w32_busy", 64'(busy1), 64'd1);
        lat = 0;
        while (!out_valid1 && lat < 20) begin
            tick();
            lat++;
        end
        chk("w32_latency", 64'(lat), 64'd1);
        chk("w32_result", 64'(result1), 64'hF0F0_0F0F);
        chk("w32_zero", 64'(zero1), 64'd0);
        out_ready1 = 1'b1;
        tick();
        out_ready1 = 1'b0;
        chk("w32_in_ready", 64'(in_ready1), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
